// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit: credit-based instruction fetch queue between imem and decode
module fetch_buffer_unit #(
  parameter int          FETCH_WORDS     = 2,
  parameter int          ISSUE_W         = 2,
  parameter int          QWORDS          = 8,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [31:0]                  imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [FETCH_WORDS*32-1:0]    imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic [ISSUE_W-1:0]           out_valid,
  output logic [ISSUE_W*32-1:0]        out_inst,
  output logic [31:0]                  out_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0] issue_count
);
  localparam int QA = $clog2(QWORDS);
  localparam int CW = QA + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(FETCH_WORDS) + 2;
  localparam int SW = FETCH_WORDS > 1 ? $clog2(FETCH_WORDS) : 1;
  localparam logic [31:0] BMASK = ~32'(FETCH_WORDS*4 - 1);

  logic [31:0]   fetch_pc, head_pc;
  logic [QA-1:0] rd, wr;
  logic [CW-1:0] count, enq_n;
  logic [IW-1:0] inflight, drop_cnt;
  logic [SW-1:0] skip, redir_skip;
  logic [31:0]   free_w, need_w;
  logic          req_fire, enq;
  logic [31:0]   q [QWORDS];

  // credits: a request is only sent if every outstanding response still fits
  assign free_w         = 32'(QWORDS) - 32'(count);
  assign need_w         = (32'(inflight) + 32'd1) * 32'(FETCH_WORDS);
  assign imem_req_valid = rst_n && !redirect_valid && (32'(inflight) < 32'(MAX_OUTSTANDING)) && (free_w >= need_w);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign enq            = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign enq_n          = enq ? CW'(FETCH_WORDS) - CW'(skip) : '0;
  assign redir_skip     = SW'(redirect_pc[BW-1:0] >> 2);
  assign out_pc         = head_pc;

  // present the oldest ISSUE_W queue words; empty slots read as zero
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i]        = count > CW'(i);
      out_inst[32*i +: 32] = out_valid[i] ? q[rd + QA'(i)] : '0;
    end
  end

  // word storage: the first bundle after a redirect skips words before the target
  always_ff @(posedge clk)
    for (int k = 0; k < FETCH_WORDS; k++)
      if (enq && k >= int'(skip)) q[wr + QA'(k) - QA'(skip)] <= imem_rsp_data[32*k +: 32];

  // pointers, counters and PCs; a redirect overrides issue and enqueue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC & BMASK;
      head_pc  <= {RESET_PC[31:2], 2'b00};
      rd       <= '0;
      wr       <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      skip     <= '0;
    end else begin
      fetch_pc <= redirect_valid ? redirect_pc & BMASK : req_fire ? fetch_pc + 32'(FETCH_WORDS*4) : fetch_pc;
      head_pc  <= redirect_valid ? {redirect_pc[31:2], 2'b00} : head_pc + (32'(issue_count) << 2);
      rd       <= redirect_valid ? '0 : rd + QA'(issue_count);
      wr       <= redirect_valid ? '0 : wr + enq_n[QA-1:0];
      count    <= redirect_valid ? '0 : count + enq_n - CW'(issue_count);
      inflight <= inflight + IW'(req_fire) - IW'(imem_rsp_valid);
      drop_cnt <= redirect_valid ? inflight - IW'(imem_rsp_valid) :
                  (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - IW'(1) : drop_cnt;
      skip     <= redirect_valid ? redir_skip : enq ? '0 : skip;
    end
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// tb_fetch_buffer_unit: random and directed checks against a queue-level fetch model
module tb_fetch_buffer_unit;
  localparam int FW = 2, IW = 2, QW = 8, MO = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 0, rst_n = 0;
  logic          imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic [31:0]   imem_req_addr, redirect_pc, out_pc;
  logic [FW*32-1:0] imem_rsp_data;
  logic [IW-1:0] out_valid;
  logic [IW*32-1:0] out_inst;
  logic [1:0]    issue_count;

  fetch_buffer_unit #(.FETCH_WORDS(FW), .ISSUE_W(IW), .QWORDS(QW), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n) assert (int'(issue_count) <= $countones(out_valid)) else $error("issue_count exceeds valid slots");

  typedef struct {logic [31:0] addr; logic [31:0] start; bit stale; int due;} fl_t;
  fl_t         infl[$];
  logic [31:0] mq[$];
  logic [31:0] mfetch, mhead, mresume;
  int          cyc, lat_max, errs, checks;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a >> 2) * 32'h9E3779B1 + 32'h1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    infl.delete();
    mfetch  = RPC & ~32'(FW*4 - 1);
    mhead   = {RPC[31:2], 2'b00};
    mresume = mhead;
  endtask

  function automatic int rnd_iss();
    int avail = mq.size() < IW ? mq.size() : IW;
    return $urandom_range(0, avail);
  endfunction

  function automatic int max_iss();
    return mq.size() < IW ? mq.size() : IW;
  endfunction

  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input int iss);
    bit  rsp, fire, exp_rv;
    fl_t e;
    @(negedge clk);
    rsp = infl.size() > 0 && infl[0].due <= cyc;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    issue_count    = 2'(iss);
    imem_rsp_valid = rsp;
    for (int k = 0; k < FW; k++)
      imem_rsp_data[32*k +: 32] = rsp ? memw(infl[0].addr + 32'(4*k)) : $urandom;
    #1;
    exp_rv = !redir && infl.size() < MO && (QW - mq.size()) >= (infl.size() + 1) * FW;
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(mfetch));
    check("out_pc", 64'(out_pc), 64'(mhead));
    for (int i = 0; i < IW; i++) begin
      check("out_valid", 64'(out_valid[i]), 64'(i < mq.size()));
      check("out_inst", 64'(out_inst[32*i +: 32]), i < mq.size() ? 64'(memw(mq[i])) : 64'h0);
    end
    fire = exp_rv && rdy;
    @(posedge clk);
    if (rsp) begin
      e = infl.pop_front();
      if (!redir && !e.stale)
        for (int w = 0; w < FW; w++)
          if (e.addr + 32'(4*w) >= e.start) mq.push_back(e.addr + 32'(4*w));
    end
    if (redir) begin
      foreach (infl[j]) infl[j].stale = 1;
      mq.delete();
      mhead   = {rpc[31:2], 2'b00};
      mresume = mhead;
      mfetch  = rpc & ~32'(FW*4 - 1);
    end else begin
      repeat (iss) void'(mq.pop_front());
      mhead += 32'(4*iss);
    end
    if (fire) begin
      e.addr  = mfetch;
      e.start = mfetch < mresume ? mresume : mfetch;
      e.stale = 0;
      e.due   = cyc + 1 + $urandom_range(0, lat_max);
      if (infl.size() > 0 && e.due <= infl[infl.size()-1].due) e.due = infl[infl.size()-1].due + 1;
      infl.push_back(e);
      mfetch += 32'(FW*4);
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data  = '0;
    redirect_valid = 0;
    redirect_pc    = '0;
    issue_count    = '0;
  endtask

  initial begin
    int t;
    idle_inputs();
    errs = 0; checks = 0; cyc = 0; lat_max = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_inst", 64'(out_inst), 64'h0);
    check("rst_out_pc", 64'(out_pc), 64'h0);
    @(negedge clk);
    rst_n = 1;

    // fill with decode stalled until the queue is full
    repeat (8) step(1, 0, 0, 0);
    #1;
    check("fill_valid", 64'(out_valid), 64'h3);
    check("fill_pc", 64'(out_pc), 64'h0);
    check("fill_no_req", 64'(imem_req_valid), 64'h0);

    // steady stream issuing two per cycle
    for (int n = 0; n < 20; n++) begin
      step(1, 0, 0, max_iss());
      #1;
      if (n >= 10) check("stream_valid", 64'(out_valid), 64'h3);
    end

    // redirect to 0x104 with two requests in flight
    lat_max = 2;
    for (t = 0; t < 40 && infl.size() < 2; t++) step(1, 0, 0, rnd_iss());
    check("inflight2_reached", 64'(infl.size()), 64'h2);
    step(1, 1, 32'h104, 0);
    #1;
    check("redir_flush", 64'(out_valid), 64'h0);
    lat_max = 0;
    for (t = 0; t < 20; t++) begin
      step(1, 0, 0, 0);
      #1;
      if (out_valid != '0) break;
    end
    check("redir_first_valid", 64'(out_valid), 64'h1);
    check("redir_first_pc", 64'(out_pc), 64'h104);
    check("redir_first_inst", 64'(out_inst[31:0]), 64'(memw(32'h104)));

    // redirect colliding with a response and a nonzero issue
    for (t = 0; t < 40 && !(infl.size() > 0 && infl[0].due <= cyc && mq.size() >= 1); t++) step(1, 0, 0, 0);
    check("collide_setup", 64'(infl.size() > 0 && infl[0].due <= cyc && mq.size() >= 1), 64'h1);
    step(1, 1, 32'h2000, mq.size() >= 1 ? 1 : 0);
    #1;
    check("collide_flush", 64'(out_valid), 64'h0);

    // random traffic with redirects and wrap-around
    lat_max = 2;
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 32'($urandom_range(0, 16'hffff)), rnd_iss());

    // reset while two requests are outstanding
    for (t = 0; t < 40 && infl.size() < 2; t++) step(1, 0, 0, rnd_iss());
    check("rst_inflight2", 64'(infl.size()), 64'h2);
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    #1;
    check("midrst_req_valid", 64'(imem_req_valid), 64'h0);
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_out_inst", 64'(out_inst), 64'h0);
    check("midrst_out_pc", 64'(out_pc), 64'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    check("postrst_req_valid", 64'(imem_req_valid), 64'h1);
    check("postrst_req_addr", 64'(imem_req_addr), 64'(RPC));
    lat_max = 1;
    for (int n = 0; n < 50; n++) step(1, 0, 0, rnd_iss());

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
